regfile_param: RTL
==================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
- REQ-001 Parameter XLEN, default 8, data width in bits (legal: 8..64).
- REQ-002 Parameter NREGS, default 8, register count (legal: power of two, 4..32).
- REQ-003 Derived constant AW = $clog2(NREGS), width of every address port.
- REQ-004 clk  in  1  single clock; all state updates on its rising edge.
- REQ-005 rst  in  1  reset; asynchronous, active-low.
- REQ-006 we3  in  1  write enable.
- REQ-007 wa3  in  AW  write address.
- REQ-008 wd3  in  XLEN  write data.
- REQ-009 ra1, ra2  in  AW  read addresses, ports 1 and 2.
- REQ-010 rd1, rd2  out  XLEN  read data, ports 1 and 2.
- REQ-011 clr_req  in  1  request to bulk-clear all registers.
- REQ-012 busy  out  1  high while a bulk clear is in progress.
- REQ-013 clr_done  out  1  one-cycle pulse when a bulk clear completes.
- REQ-014 dbg_addr  in  AW  debug read address.
- REQ-015 dbg_data  out  XLEN  debug read data.

Function
- REQ-016 Register 0 SHALL read as zero on rd1, rd2 and dbg_data; writes to address 0 SHALL be discarded.
- REQ-017 Reads SHALL be combinational: rd1 = reg[ra1], rd2 = reg[ra2], dbg_data = reg[dbg_addr].
- REQ-018 When we3=1, busy=0 and wa3!=0, reg[wa3] SHALL take wd3 at the next rising edge.
- REQ-019 The clear FSM SHALL have two states, IDLE and CLEAR.
- REQ-020 In IDLE, clr_req=1 SHALL move the FSM to CLEAR, load index=1, and raise busy on the next cycle.
- REQ-021 In CLEAR, reg[index] SHALL be zeroed and index incremented each cycle; zeroing index NREGS-1 SHALL return the FSM to IDLE with a clr_done pulse.
- REQ-022 A full clear SHALL take exactly NREGS-1 cycles with busy=1, followed by clr_done=1 for one cycle, during which busy=0.
- REQ-023 While busy=1, we3 SHALL be ignored, so that write is lost, and clr_req SHALL be ignored.
- REQ-024 Reads SHALL remain valid during CLEAR; already-cleared registers SHALL read zero.
- REQ-025 In IDLE, a clr_req coincident with we3 SHALL let the write land; the clear then starts the following cycle and zeroes it.
- REQ-026 The index counter SHALL be AW bits wide and SHALL NOT wrap past NREGS-1.

Reset
- REQ-027 With rst=0, all registers SHALL be zero, the FSM SHALL be in IDLE, index=1, busy=0 and clr_done=0, independent of clk.
- REQ-028 Reset asserted mid-CLEAR SHALL abort the clear; no clr_done pulse SHALL follow.

Configuration
- REQ-029 With REGFILE_BYPASS_EN defined, a read port whose address equals wa3 (nonzero) while we3=1 and busy=0 SHALL return wd3 in the same cycle.
- REQ-030 The bypass SHALL apply to rd1 and rd2 only, not to dbg_data.
- REQ-031 Without REGFILE_BYPASS_EN, read ports SHALL return the stored value until the clock edge.

Structure
- REQ-032 Package regfile_pkg SHALL hold the default XLEN/NREGS constants and the FSM state enum clr_state_t {IDLE, CLEAR}.
- REQ-033 The FSM and index counter SHALL be a sub-module, regfile_clear_fsm, with outputs busy, clr_done, clr_we and clr_idx.
- REQ-034 Storage and read muxing SHALL remain in regfile_param.

Verification (XLEN=8, NREGS=8)
- REQ-035 Reset, write 0x5A to r3, ra1=3 -> rd1=0x5A next cycle; write 0xFF to r0, ra2=0 -> rd2=0x00.
- REQ-036 Bypass on: we3=1, wa3=4, wd3=0x11, ra1=4 -> rd1=0x11 in the same cycle; bypass off -> rd1=old value, 0x11 after the edge.
- REQ-037 Load r1..r7 = 0x01..0x07, pulse clr_req -> busy high 7 cycles, clr_done pulse, every dbg_addr reads 0x00.
- REQ-038 we3=1, wa3=2, wd3=0x33 during CLEAR -> r2 stays 0x00 after clr_done.
- REQ-039 rst=0 three cycles into CLEAR -> busy=0 and all registers 0 immediately; no clr_done.
- REQ-040 clr_req with we3 (wa3=7, wd3=0x77) in IDLE -> r7 reads 0x77, then 0x00 after the clear.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the parameterised register file.
// The optional same-cycle write-to-read bypass is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

  // Default geometry: 8 registers of 8 bits each.
  localparam int unsigned DefaultXlen  = 8;
  localparam int unsigned DefaultNregs = 8;

  // Legal geometry limits.
  localparam int unsigned MinXlen  = 8;
  localparam int unsigned MaxXlen  = 64;
  localparam int unsigned MinNregs = 4;
  localparam int unsigned MaxNregs = 32;

  // Bulk-clear sequencer states.
  typedef enum logic [0:0] {
    IDLE,
    CLEAR
  } clr_state_t;

  // True when v is a non-zero power of two.
  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks an index from 1 to NREGS-1, issuing one zeroing
// write per cycle, then emits a single-cycle completion pulse.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = DefaultNregs,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  // Register 0 is hard-wired to zero, so the walk starts at 1.
  localparam logic [AW-1:0] FirstIdx = AW'(1);
  localparam logic [AW-1:0] LastIdx  = AW'(NREGS - 1);

  clr_state_t    state_q;
  logic [AW-1:0] idx_q;
  logic          busy_q;
  logic          done_q;

  // Sequencer state, index counter and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= FirstIdx;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q <= CLEAR;
            idx_q   <= FirstIdx;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          // Stop on the last register rather than letting the counter wrap.
          if (idx_q == LastIdx) begin
            state_q <= IDLE;
            idx_q   <= FirstIdx;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + FirstIdx;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= FirstIdx;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign clr_done = done_q;
  assign clr_we   = busy_q;
  assign clr_idx  = idx_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file: one write port, two combinational read ports,
// a debug read port and a bulk-clear sequencer. Register 0 reads as zero.
// Define REGFILE_BYPASS_EN to forward a pending write to rd1/rd2 in the same
// cycle; dbg_data always reflects stored contents.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = DefaultXlen,
  parameter int unsigned NREGS = DefaultNregs,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we3,
  input  logic [AW-1:0]   wa3,
  input  logic [XLEN-1:0] wd3,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            clr_req,
  output logic            busy,
  output logic            clr_done,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // Elaboration-time geometry guard.
  if (XLEN < MinXlen || XLEN > MaxXlen) begin : g_bad_xlen
    $error("regfile_param: XLEN out of range");
  end
  if (NREGS < MinNregs || NREGS > MaxNregs || !is_pow2(NREGS)) begin : g_bad_nregs
    $error("regfile_param: NREGS must be a power of two in range");
  end

  logic [XLEN-1:0] regs_q [NREGS];

  logic          clr_we;
  logic [AW-1:0] clr_idx;
  logic          host_we;

  regfile_clear_fsm #(
    .NREGS (NREGS)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  // Host writes are dropped while clearing and when aimed at register 0.
  assign host_we = we3 && !busy && (wa3 != '0);

  // Storage: the clear sequencer and the host never write in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (clr_we) begin
      regs_q[clr_idx] <= '0;
    end else if (host_we) begin
      regs_q[wa3] <= wd3;
    end
  end

  // Stored value at an address, with register 0 forced to zero.
  function automatic logic [XLEN-1:0] stored(input logic [AW-1:0] addr);
    return (addr == '0) ? '0 : regs_q[addr];
  endfunction

  // Read muxing for the two data ports and the debug port.
  always_comb begin
    rd1      = stored(ra1);
    rd2      = stored(ra2);
    dbg_data = stored(dbg_addr);
`ifdef REGFILE_BYPASS_EN
    if (host_we && (wa3 == ra1)) begin
      rd1 = wd3;
    end
    if (host_we && (wa3 == ra2)) begin
      rd2 = wd3;
    end
`endif
  end

endmodule
